// File: rtl/pl_stage_5_if.sv
// Bus bundle for pl_stage_5: pipeline control, the r0 coefficient write port,
// the upstream inverse-NTT read port and the compressed byte write port.
// Optional macro PL_STAGE5_SUM_TAP_EN adds the sum tap signals.
// The slave modport is the stage itself; the master modport is its environment.
interface pl_stage_5_if;
  logic        en;
  logic        start_stage;
  logic        done_stage;
  logic        we_r0;
  logic [8:0]  addr_r0;
  logic [15:0] dout_r0;
  logic [8:0]  addr_bntt;
  logic [15:0] do_bntt;
  logic        we_c;
  logic [7:0]  addr_c;
  logic [7:0]  dout_c;
`ifdef PL_STAGE5_SUM_TAP_EN
  logic        we_v;
  logic [8:0]  addr_v;
  logic [15:0] dout_v;
`endif

  modport master (
    output en,
    output start_stage,
    output we_r0,
    output addr_r0,
    output dout_r0,
    output do_bntt,
    input  done_stage,
    input  addr_bntt,
    input  we_c,
    input  addr_c,
`ifdef PL_STAGE5_SUM_TAP_EN
    input  we_v,
    input  addr_v,
    input  dout_v,
`endif
    input  dout_c
  );

  modport slave (
    input  en,
    input  start_stage,
    input  we_r0,
    input  addr_r0,
    input  dout_r0,
    input  do_bntt,
    output done_stage,
    output addr_bntt,
    output we_c,
    output addr_c,
`ifdef PL_STAGE5_SUM_TAP_EN
    output we_v,
    output addr_v,
    output dout_v,
`endif
    output dout_c
  );
endinterface

// File: rtl/pl_stage_5.sv
// pl_stage_5: adds the stored A+E' coefficients (r0) to the inverse-NTT output
// mod Q, compresses each sum to 3 bits and packs eight 3-bit values into three
// bytes, writing the 192-byte compressed polynomial.
// Optional macro PL_STAGE5_SUM_TAP_EN exposes each mod-Q sum on we_v/addr_v/dout_v.
module pl_stage_5 #(
  parameter int Q = 12289
) (
  input logic         clk,
  input logic         rst,
  pl_stage_5_if.slave bus
);

  localparam int          HALF_Q    = Q / 2;
  localparam logic [15:0] Q16       = 16'(Q);
  localparam logic [8:0]  LAST_IDX  = 9'd511;
  localparam logic [7:0]  LAST_BYTE = 8'd191;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic        en;
  logic        issue;
  logic        start_ok;
  logic        last_write;

  logic [8:0]  idx;
  logic [15:0] r0_mem [512];
  logic [15:0] r0_q;

  logic        hold_full;
  logic [15:0] bntt_hold;
  logic [15:0] bntt_eff;

  logic        v1;
  logic        v2;
  logic        v3;

  logic [15:0] raw_sum;
  logic [15:0] sum_next;
  logic [15:0] sum_q;

  logic [19:0] scaled;
  logic [2:0]  c_next;
  logic [2:0]  c_q;

  logic [20:0] grp;
  logic [2:0]  slot;
  logic [23:0] full_grp;
  logic [15:0] out_buf;
  logic [1:0]  pend;

  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  dout_q;
  logic [7:0]  byte_cnt;

  assign en         = bus.en;
  assign issue      = en && (state == RUN);
  assign start_ok   = en && bus.start_stage && (state == IDLE);
  assign last_write = we_q && (addr_q == LAST_BYTE);

  // State register; en low freezes the FSM in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Next-state logic: start only from IDLE, drain after the final address,
  // finish once the last byte has been written, then return to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_stage) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DRAIN;
      DRAIN:   if (last_write) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared read index for the upstream RAM and the local r0 RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (start_ok) begin
      idx <= '0;
    end else if (issue) begin
      idx <= idx + 9'd1;
    end
  end

  assign bus.addr_bntt = idx;

  // r0 coefficient RAM write port, open in every state.
  always_ff @(posedge clk) begin
    if (bus.we_r0) begin
      r0_mem[bus.addr_r0] <= bus.dout_r0;
    end
  end

  // r0 synchronous read; a same-cycle write to this address yields the old word.
  always_ff @(posedge clk) begin
    if (en) begin
      r0_q <= r0_mem[idx];
    end
  end

  // The upstream RAM keeps reading the held address while we are frozen, so
  // its output is captured on the first frozen edge and replayed on resume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      bntt_hold <= '0;
    end else if (en) begin
      hold_full <= 1'b0;
    end else if (!hold_full) begin
      hold_full <= 1'b1;
      bntt_hold <= bus.do_bntt;
    end
  end

  assign bntt_eff = hold_full ? bntt_hold : bus.do_bntt;

  // Valid bits for read-data, sum and compress stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= issue;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Modular addition with a single conditional subtract (inputs below Q).
  always_comb begin
    raw_sum  = r0_q + bntt_eff;
    sum_next = raw_sum;
    if (raw_sum >= Q16) begin
      sum_next = raw_sum - Q16;
    end
  end

  // Sum register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (en && v1) begin
      sum_q <= sum_next;
    end
  end

  // Compression: count how many multiples of Q lie at or below 8*s + Q/2,
  // which is floor((8*s + Q/2) / Q); reaching 8 wraps back to 0.
  always_comb begin
    scaled = {1'b0, sum_q, 3'b000} + 20'(HALF_Q);
    c_next = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (scaled >= 20'(k * Q)) begin
        c_next = 3'(k);
      end
    end
    if (scaled >= 20'(8 * Q)) begin
      c_next = 3'd0;
    end
  end

  // Compressed value register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
    end else if (en && v2) begin
      c_q <= c_next;
    end
  end

  // Seven values wait in grp (t0 in the low bits); the eighth completes the
  // 24-bit little-endian group that splits directly into B0, B1, B2.
  assign full_grp = {c_q, grp};

  // Packing and byte emission: B0 leaves as the group completes, B1 and B2
  // on the next two enabled cycles, well before the next group fills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp      <= '0;
      slot     <= '0;
      out_buf  <= '0;
      pend     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      byte_cnt <= '0;
    end else if (start_ok) begin
      slot     <= '0;
      pend     <= '0;
      we_q     <= 1'b0;
      byte_cnt <= '0;
    end else if (en) begin
      we_q <= 1'b0;
      if (v3) begin
        slot <= slot + 3'd1;
        if (slot == 3'd7) begin
          we_q     <= 1'b1;
          dout_q   <= full_grp[7:0];
          addr_q   <= byte_cnt;
          byte_cnt <= byte_cnt + 8'd1;
          out_buf  <= full_grp[23:8];
          pend     <= 2'd2;
        end else begin
          grp <= {c_q, grp[20:3]};
        end
      end
      if ((pend != 2'd0) && !(v3 && (slot == 3'd7))) begin
        we_q     <= 1'b1;
        dout_q   <= out_buf[7:0];
        out_buf  <= {8'h00, out_buf[15:8]};
        addr_q   <= byte_cnt;
        byte_cnt <= byte_cnt + 8'd1;
        pend     <= pend - 2'd1;
      end
    end
  end

  assign bus.we_c       = we_q && en;
  assign bus.addr_c     = addr_q;
  assign bus.dout_c     = dout_q;
  assign bus.done_stage = (state == DONE) && en;

`ifdef PL_STAGE5_SUM_TAP_EN
  logic [8:0] a1;
  logic [8:0] a2;

  // Index tracking alongside the valid bits so the tap carries i with s[i].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1 <= '0;
      a2 <= '0;
    end else if (en) begin
      if (issue) begin
        a1 <= idx;
      end
      if (v1) begin
        a2 <= a1;
      end
    end
  end

  assign bus.we_v   = v2 && en;
  assign bus.addr_v = a2;
  assign bus.dout_v = sum_q;
`endif

endmodule
